// File: rtl/axi_dma_pkg.sv
// Shared constants, FSM encodings and helpers for the AXI DMA read and write masters.
package axi_dma_pkg;

    localparam int unsigned FIXED_BURST_SIZE = 256;

    localparam logic [2:0] SIZE_1B = 3'b000;
    localparam logic [2:0] SIZE_2B = 3'b001;
    localparam logic [2:0] SIZE_4B = 3'b010;
    localparam logic [2:0] SIZE_8B = 3'b011;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] QOS_MAX = 4'hF;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_PRE   = 2'd1,
        RD_START = 2'd2,
        RD_SEQ   = 2'd3
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_PRE   = 2'd1,
        WR_START = 2'd2,
        WR_SEQ   = 2'd3
    } wr_state_t;

    // Beats in the next burst: the remaining count, capped at one full burst.
    function automatic logic [8:0] burst_len(input logic [31:0] remaining);
        if (remaining >= 32'(FIXED_BURST_SIZE)) begin
            return 9'(FIXED_BURST_SIZE);
        end
        return 9'(remaining);
    endfunction

endpackage

// File: rtl/axi_dma_rd_fifo.sv
// Synchronous-read FIFO buffering R beats when AXI_DMA_RD_FIFO_EN is defined.
module axi_dma_rd_fifo #(
    parameter int unsigned depth = 16,
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             rd_en,
    output logic [width-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count == (AW+1)'(depth));
    assign empty = (count == '0);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end

endmodule

// File: rtl/axi_dma_rd.sv
// AXI4 read DMA master: splits num_trans beats into INCR bursts of up to 256 and streams data out.
// Optional R-beat buffering is enabled by defining AXI_DMA_RD_FIFO_EN.
module axi_dma_rd
    import axi_dma_pkg::*;
#(
    parameter int unsigned OUT_BITS_TRANS = 13,
    parameter int unsigned AXI_WIDTH_ID   = 4,
    parameter int unsigned AXI_WIDTH_AD   = 32,
    parameter int unsigned AXI_WIDTH_DA   = 32
) (
    input  logic                      clk,
    input  logic                      rstn,

    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,
    output logic [AXI_WIDTH_AD-1:0]   M_ARADDR,
    output logic [AXI_WIDTH_ID-1:0]   M_ARID,
    output logic [7:0]                M_ARLEN,
    output logic [2:0]                M_ARSIZE,
    output logic [1:0]                M_ARBURST,
    output logic [1:0]                M_ARLOCK,
    output logic [3:0]                M_ARCACHE,
    output logic [2:0]                M_ARPROT,
    output logic [3:0]                M_ARQOS,
    output logic [3:0]                M_ARREGION,
    output logic [3:0]                M_ARUSER,

    input  logic                      M_RVALID,
    output logic                      M_RREADY,
    input  logic [AXI_WIDTH_DA-1:0]   M_RDATA,
    input  logic [1:0]                M_RRESP,
    input  logic                      M_RLAST,
    input  logic [AXI_WIDTH_ID-1:0]   M_RID,
    input  logic                      M_RUSER,

    input  logic                      start_dma,
    input  logic [OUT_BITS_TRANS-1:0] num_trans,
    input  logic [AXI_WIDTH_AD-1:0]   start_addr,
    output logic                      done_o,

    output logic [AXI_WIDTH_DA-1:0]   outdata,
    output logic                      outdata_valid,
    input  logic                      outdata_ready,
    output logic                      fail_check
);

    rd_state_t                 state_q;
    rd_state_t                 state_d;
    logic [OUT_BITS_TRANS-1:0] num_q;
    logic [OUT_BITS_TRANS-1:0] issued_q;
    logic [AXI_WIDTH_AD-1:0]   addr_q;
    logic [8:0]                len_q;
    logic [7:0]                beat_q;
    logic                      arvalid_q;
    logic                      done_q;
    logic                      fail_q;

    logic                      done_set;
    logic                      beat_acc;
    logic                      last_beat;
    logic                      all_issued;
    logic                      drained;
    logic                      unused_r;

    // ID and user sideband are not needed on the read data path.
    assign unused_r = ^{M_RID, M_RUSER};

    assign M_ARVALID  = arvalid_q;
    assign M_ARADDR   = addr_q;
    assign M_ARLEN    = 8'(len_q - 9'd1);
    assign M_ARID     = '0;
    assign M_ARSIZE   = SIZE_4B;
    assign M_ARBURST  = BURST_INCR;
    assign M_ARLOCK   = 2'b00;
    assign M_ARCACHE  = 4'h0;
    assign M_ARPROT   = 3'h0;
    assign M_ARQOS    = QOS_MAX;
    assign M_ARREGION = 4'h0;
    assign M_ARUSER   = 4'h0;

    assign done_o     = done_q;
    assign fail_check = fail_q;

    assign beat_acc   = M_RVALID && M_RREADY;
    assign last_beat  = (beat_q == 8'(len_q - 9'd1));
    assign all_issued = (issued_q == num_q);

`ifdef AXI_DMA_RD_FIFO_EN
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    logic ovalid_q;

    axi_dma_rd_fifo #(
        .depth (16),
        .width (AXI_WIDTH_DA)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (beat_acc),
        .wr_data (M_RDATA),
        .rd_en   (fifo_pop),
        .rd_data (outdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign M_RREADY      = !fifo_full && (state_q == RD_SEQ);
    assign fifo_pop      = !fifo_empty && (!ovalid_q || outdata_ready);
    assign outdata_valid = ovalid_q;
    assign drained       = fifo_empty && !ovalid_q;

    // Output stage valid: loaded on pop, held until the consumer takes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovalid_q <= 1'b0;
        end else begin
            ovalid_q <= fifo_pop || (ovalid_q && !outdata_ready);
        end
    end
`else
    assign M_RREADY      = outdata_ready && (state_q == RD_SEQ);
    assign outdata       = M_RDATA;
    assign outdata_valid = M_RVALID && (state_q == RD_SEQ);
    assign drained       = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        done_set = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (start_dma) begin
                    state_d = RD_PRE;
                end
            end
            RD_PRE: begin
                if (!all_issued) begin
                    state_d = RD_START;
                end else if (drained) begin
                    state_d  = RD_IDLE;
                    done_set = 1'b1;
                end
            end
            RD_START: begin
                if (M_ARVALID && M_ARREADY) begin
                    state_d = RD_SEQ;
                end
            end
            RD_SEQ: begin
                if (beat_acc && last_beat) begin
                    state_d = RD_PRE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Transfer bookkeeping; the burst ends on the beat count, RLAST is only checked.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_q     <= '0;
            issued_q  <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            arvalid_q <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            done_q <= done_set;
            fail_q <= beat_acc && ((M_RRESP != RESP_OKAY) || (M_RLAST != last_beat));
            case (state_q)
                RD_IDLE: begin
                    if (start_dma) begin
                        num_q    <= num_trans;
                        addr_q   <= start_addr;
                        issued_q <= '0;
                    end
                end
                RD_PRE: begin
                    if (!all_issued) begin
                        len_q     <= burst_len(32'(num_q - issued_q));
                        beat_q    <= '0;
                        arvalid_q <= 1'b1;
                    end
                end
                RD_START: begin
                    if (M_ARREADY) begin
                        arvalid_q <= 1'b0;
                    end
                end
                RD_SEQ: begin
                    if (beat_acc) begin
                        if (last_beat) begin
                            issued_q <= issued_q + OUT_BITS_TRANS'(len_q);
                            addr_q   <= addr_q + AXI_WIDTH_AD'({len_q, 2'b00});
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dma_rd.sv
// Self-checking bench for axi_dma_rd: table of transfers plus zero-length and mid-burst reset sequences.
module tb_axi_dma_rd;

    localparam int unsigned NT = 13;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        int          n;
        logic [31:0] addr;
        int          ar_delay;
        bit          toggle;
        int          err_beat;
        int          bad_last;
        bit          spurious;
        int          exp_ars;
        int          exp_fail;
    } vec_t;

    logic          clk;
    logic          rstn;
    logic          M_ARVALID;
    logic          M_ARREADY;
    logic [31:0]   M_ARADDR;
    logic [3:0]    M_ARID;
    logic [7:0]    M_ARLEN;
    logic [2:0]    M_ARSIZE;
    logic [1:0]    M_ARBURST;
    logic [1:0]    M_ARLOCK;
    logic [3:0]    M_ARCACHE;
    logic [2:0]    M_ARPROT;
    logic [3:0]    M_ARQOS;
    logic [3:0]    M_ARREGION;
    logic [3:0]    M_ARUSER;
    logic          M_RVALID;
    logic          M_RREADY;
    logic [31:0]   M_RDATA;
    logic [1:0]    M_RRESP;
    logic          M_RLAST;
    logic [3:0]    M_RID;
    logic          M_RUSER;
    logic          start_dma;
    logic [NT-1:0] num_trans;
    logic [31:0]   start_addr;
    logic          done_o;
    logic [31:0]   outdata;
    logic          outdata_valid;
    logic          outdata_ready;
    logic          fail_check;

    axi_dma_rd #(
        .OUT_BITS_TRANS (NT),
        .AXI_WIDTH_ID   (4),
        .AXI_WIDTH_AD   (32),
        .AXI_WIDTH_DA   (32)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .M_ARVALID     (M_ARVALID),
        .M_ARREADY     (M_ARREADY),
        .M_ARADDR      (M_ARADDR),
        .M_ARID        (M_ARID),
        .M_ARLEN       (M_ARLEN),
        .M_ARSIZE      (M_ARSIZE),
        .M_ARBURST     (M_ARBURST),
        .M_ARLOCK      (M_ARLOCK),
        .M_ARCACHE     (M_ARCACHE),
        .M_ARPROT      (M_ARPROT),
        .M_ARQOS       (M_ARQOS),
        .M_ARREGION    (M_ARREGION),
        .M_ARUSER      (M_ARUSER),
        .M_RVALID      (M_RVALID),
        .M_RREADY      (M_RREADY),
        .M_RDATA       (M_RDATA),
        .M_RRESP       (M_RRESP),
        .M_RLAST       (M_RLAST),
        .M_RID         (M_RID),
        .M_RUSER       (M_RUSER),
        .start_dma     (start_dma),
        .num_trans     (num_trans),
        .start_addr    (start_addr),
        .done_o        (done_o),
        .outdata       (outdata),
        .outdata_valid (outdata_valid),
        .outdata_ready (outdata_ready),
        .fail_check    (fail_check)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    ar_t         exp_ar[$];
    ar_t         r_q[$];

    int  ar_delay    = 0;
    bit  toggle_mode = 1'b0;
    int  err_abs     = -1;
    int  last_abs    = -1;

    int  done_cnt = 0, fail_cnt = 0, got_cnt = 0, ar_cnt = 0, rbeat_g = 0;
    int  done_base, fail_base, got_base, ar_base;
    bit  r_active = 1'b0;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // AR slave: delayed ARREADY, stability while pending, scoreboard of address/length.
    initial begin : ar_slave
        logic [31:0] hold_addr;
        logic [7:0]  hold_len;
        bit          ar_pending;
        int          wcnt;
        ar_t         e;
        M_ARREADY  = 1'b0;
        ar_pending = 1'b0;
        wcnt       = 0;
        hold_addr  = '0;
        hold_len   = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                ar_pending = 1'b0;
            end else if (M_ARVALID) begin
                if (!ar_pending) begin
                    ar_pending = 1'b1;
                    hold_addr  = M_ARADDR;
                    hold_len   = M_ARLEN;
                    wcnt       = 0;
                end else begin
                    check("araddr_stable", 64'(M_ARADDR), 64'(hold_addr));
                    check("arlen_stable", 64'(M_ARLEN), 64'(hold_len));
                end
                if (M_ARREADY) begin
                    ar_cnt++;
                    check("ar_expected", 64'(exp_ar.size() != 0), 64'(1));
                    check("ar_one_outstanding", 64'(r_active || (r_q.size() != 0)), 64'(0));
                    check("ar_consts",
                          64'({M_ARID, M_ARSIZE, M_ARBURST, M_ARLOCK, M_ARCACHE,
                               M_ARPROT, M_ARQOS, M_ARREGION, M_ARUSER}),
                          64'({4'h0, 3'b010, 2'b01, 2'b00, 4'h0, 3'h0, 4'hF, 4'h0, 4'h0}));
                    if (exp_ar.size() != 0) begin
                        e = exp_ar.pop_front();
                        check("araddr", 64'(M_ARADDR), 64'(e.addr));
                        check("arlen", 64'(M_ARLEN), 64'(e.len));
                    end
                    r_q.push_back('{addr: M_ARADDR, len: M_ARLEN});
                    ar_pending = 1'b0;
                end
            end
            @(posedge clk); #1;
            if (rstn && ar_pending) begin
                M_ARREADY = (wcnt >= ar_delay);
                wcnt++;
            end else begin
                M_ARREADY = 1'b0;
            end
        end
    end

    // R slave: serves accepted bursts in order with error and RLAST corruption hooks.
    initial begin : r_slave
        ar_t cur;
        int  bidx;
        cur      = '0;
        bidx     = 0;
        M_RVALID = 1'b0;
        M_RDATA  = '0;
        M_RRESP  = 2'b00;
        M_RLAST  = 1'b0;
        M_RID    = '0;
        M_RUSER  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                r_active = 1'b0;
                r_q.delete();
            end else if (M_RVALID && M_RREADY) begin
                bidx++;
                rbeat_g++;
                if (bidx == int'(cur.len) + 1) r_active = 1'b0;
            end
            @(posedge clk); #1;
            if (rstn && !r_active && (r_q.size() != 0)) begin
                cur      = r_q.pop_front();
                r_active = 1'b1;
                bidx     = 0;
            end
            if (rstn && r_active) begin
                M_RVALID = 1'b1;
                M_RDATA  = pat(cur.addr + 32'(4 * bidx));
                M_RRESP  = (rbeat_g == err_abs) ? 2'b10 : 2'b00;
                M_RLAST  = (bidx == int'(cur.len)) ^ (rbeat_g == last_abs);
            end else begin
                M_RVALID = 1'b0;
                M_RDATA  = '0;
                M_RRESP  = 2'b00;
                M_RLAST  = 1'b0;
            end
        end
    end

    // Consumer: backpressure and in-order data scoreboard, pulse counters.
    initial begin : consumer
        logic [31:0] e;
        outdata_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (outdata_valid && outdata_ready) begin
                    got_cnt++;
                    check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("outdata", 64'(outdata), 64'(e));
                    end
                end
                if (done_o) done_cnt++;
                if (fail_check) fail_cnt++;
            end
            @(posedge clk); #1;
            outdata_ready = toggle_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic prep(input vec_t v);
        int          rem;
        int          len;
        logic [31:0] a;
        exp_q.delete();
        exp_ar.delete();
        for (int k = 0; k < v.n; k++) exp_q.push_back(pat(v.addr + 32'(4 * k)));
        rem = v.n;
        a   = v.addr;
        while (rem > 0) begin
            len = (rem > 256) ? 256 : rem;
            exp_ar.push_back('{addr: a, len: 8'(len - 1)});
            a   = a + 32'(len * 4);
            rem = rem - len;
        end
        ar_delay    = v.ar_delay;
        toggle_mode = v.toggle;
        err_abs     = (v.err_beat < 0) ? -1 : rbeat_g + v.err_beat;
        last_abs    = (v.bad_last < 0) ? -1 : rbeat_g + v.bad_last;
        done_base   = done_cnt;
        fail_base   = fail_cnt;
        got_base    = got_cnt;
        ar_base     = ar_cnt;
    endtask

    task automatic kick(input vec_t v);
        @(posedge clk); #1;
        start_dma  = 1'b1;
        num_trans  = NT'(v.n);
        start_addr = v.addr;
        @(posedge clk); #1;
        start_dma  = 1'b0;
        num_trans  = '1;
        start_addr = 32'hFFFF_0000;
    endtask

    task automatic run_case(input vec_t v);
        int cyc;
        prep(v);
        kick(v);
        cyc = 0;
        while ((done_cnt == done_base) && (cyc < v.n * 4 + 300)) begin
            @(posedge clk); #1;
            cyc++;
            if (v.spurious && cyc == 20) begin
                start_dma  = 1'b1;
                num_trans  = NT'(5);
                start_addr = 32'hDEAD_0000;
            end else begin
                start_dma = 1'b0;
            end
        end
        start_dma = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("done_count", 64'(done_cnt - done_base), 64'(1));
        check("beat_count", 64'(got_cnt - got_base), 64'(v.n));
        check("beats_left", 64'(exp_q.size()), 64'(0));
        check("ar_count", 64'(ar_cnt - ar_base), 64'(v.exp_ars));
        check("ars_left", 64'(exp_ar.size()), 64'(0));
        check("fail_pulses", 64'(fail_cnt - fail_base), 64'(v.exp_fail));
    endtask

    initial begin : main
        int   cyc;
        vec_t z;
        rstn       = 1'b0;
        start_dma  = 1'b0;
        num_trans  = '0;
        start_addr = '0;

        //            n    addr          dly tog err bad sp ars fail
        vecs[0] = '{ 10, 32'h0000_1000, 0, 1'b0, -1, -1, 1'b0, 1, 0};
        vecs[1] = '{600, 32'h0000_0000, 0, 1'b0, -1, -1, 1'b0, 3, 0};
        vecs[2] = '{512, 32'h0000_2000, 1, 1'b0, -1, -1, 1'b0, 2, 0};
        vecs[3] = '{ 37, 32'h0000_3000, 5, 1'b1, -1, -1, 1'b0, 1, 0};
        vecs[4] = '{ 10, 32'h0000_4000, 0, 1'b0,  2, -1, 1'b0, 1, 1};
        vecs[5] = '{300, 32'h0000_5000, 5, 1'b1, -1, -1, 1'b1, 2, 0};
        vecs[6] = '{  8, 32'h0000_7000, 0, 1'b0, -1,  4, 1'b0, 1, 1};
        vecs[7] = '{  1, 32'h0000_7800, 0, 1'b1, -1,  0, 1'b0, 1, 1};

        repeat (3) @(negedge clk);
        check("rst_arvalid", 64'(M_ARVALID), 64'(0));
        check("rst_rready", 64'(M_RREADY), 64'(0));
        check("rst_outvalid", 64'(outdata_valid), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_fail", 64'(fail_check), 64'(0));
        check("rst_outdata", 64'(outdata), 64'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Zero-length transfer: done two cycles after start, no AR.
        z = '{0, 32'h0000_0100, 0, 1'b0, -1, -1, 1'b0, 0, 0};
        prep(z);
        @(posedge clk); #1;
        num_trans  = '0;
        start_addr = z.addr;
        start_dma  = 1'b1;
        @(posedge clk); #1;
        start_dma  = 1'b0;
        @(negedge clk);
        check("zero_done_c1", 64'(done_o), 64'(0));
        @(negedge clk);
        check("zero_done_c2", 64'(done_o), 64'(1));
        @(negedge clk);
        check("zero_done_c3", 64'(done_o), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        check("zero_no_ar", 64'(ar_cnt - ar_base), 64'(0));

        for (int i = 0; i < 8; i++) run_case(vecs[i]);

        // Reset at beat 100 of 300, then a clean 4-beat transfer.
        z = '{300, 32'h0000_8000, 0, 1'b0, -1, -1, 1'b0, 2, 0};
        prep(z);
        kick(z);
        cyc = 0;
        while ((got_cnt - got_base < 100) && (cyc < 2000)) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reached_beat_100", 64'(got_cnt - got_base >= 100), 64'(1));
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_arvalid", 64'(M_ARVALID), 64'(0));
        check("midrst_rready", 64'(M_RREADY), 64'(0));
        check("midrst_outvalid", 64'(outdata_valid), 64'(0));
        check("midrst_done", 64'(done_o), 64'(0));
        check("midrst_fail", 64'(fail_check), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        rstn      = 1'b1;
        done_base = done_cnt;
        ar_base   = ar_cnt;
        repeat (20) @(negedge clk);
        check("no_done_after_reset", 64'(done_cnt - done_base), 64'(0));
        check("no_ar_after_reset", 64'(ar_cnt - ar_base), 64'(0));
        z = '{4, 32'h0000_9000, 0, 1'b0, -1, -1, 1'b0, 1, 0};
        run_case(z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
